put_fsm: RTL and testbench

- Sub-FSM of the cache controller that executes the PUT (SET) command. It is the write-side counterpart of the GET sub-FSM.
- Sequence: issues a key lookup, then picks the target slot. On a hit it overwrites the existing entry; on a miss it allocates a free slot; if there is no free slot it reports FULL.
- Drives a write request to the entry store with a req/ack handshake and a timeout.
- Reports completion or error to the top-level controller through the shared sub-command struct.

---
 rtl/ctrl_types_pkg.sv | 32 +++
 rtl/put_fsm.sv | 137 +++++++++++++
 tb/tb_put_fsm.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_types_pkg.sv
// Shared types for the cache-controller sub-FSMs: PUT sub-state encoding,
// error codes and the sub-command status struct reported to the top FSM.
package ctrl_types_pkg;

  // PUT sub-FSM states.
  typedef enum logic [2:0] {
    PutIdle   = 3'd0,
    PutLookup = 3'd1,
    PutWait   = 3'd2,
    PutWrite  = 3'd3,
    PutDone   = 3'd4,
    PutError  = 3'd5
  } put_substate_e;

  // Error codes carried in sub_cmd_t.
  typedef enum logic [1:0] {
    ErrNone    = 2'd0,
    ErrFull    = 2'd1,
    ErrTimeout = 2'd2
  } err_code_e;

  // Completion or error status from a sub-FSM to the top controller.
  typedef struct packed {
    logic      done;
    logic      error;
    err_code_e err_code;
  } sub_cmd_t;

  // Width of the lookup-latency counter; LOOKUP_LAT is limited to 1..7.
  localparam int unsigned LatCntW = 3;

endpackage : ctrl_types_pkg

// File: rtl/put_fsm.sv
// PUT (SET) sub-FSM: looks up the key, selects a hit slot or a free slot,
// issues a write to the entry store with an ack timeout and reports the
// result through sub_cmd_t. All outputs are decoded from registers only.
module put_fsm
  import ctrl_types_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned LOOKUP_LAT  = 1,
  parameter int unsigned ACK_TIMEOUT = 15,
  localparam int unsigned IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             enter,
  input  logic             hit,
  input  logic [IDX_W-1:0] hit_idx,
  input  logic             free_valid,
  input  logic [IDX_W-1:0] free_idx,
  input  logic             wr_ack,
  output logic             lookup_req,
  output logic             wr_req,
  output logic [IDX_W-1:0] wr_idx,
  output logic             wr_update,
  output sub_cmd_t         cmd
);

  localparam int unsigned ToCntW = $clog2(ACK_TIMEOUT + 1);

  put_substate_e      state_q, state_d;
  logic [LatCntW-1:0] lat_cnt_q, lat_cnt_d;
  logic [ToCntW-1:0]  to_cnt_q, to_cnt_d;
  logic [ToCntW-1:0]  to_cnt_inc;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic               wr_update_q, wr_update_d;
  err_code_e          err_code_q, err_code_d;

  assign to_cnt_inc = to_cnt_q + 1'b1;

  // Next-state logic: enter restarts the command, otherwise advance only when en=1.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    to_cnt_d    = to_cnt_q;
    wr_idx_d    = wr_idx_q;
    wr_update_d = wr_update_q;
    err_code_d  = err_code_q;

    if (enter) begin
      // Abort whatever was in flight; no done/error for the aborted command.
      state_d    = PutLookup;
      lat_cnt_d  = '0;
      to_cnt_d   = '0;
      err_code_d = ErrNone;
    end else if (en) begin
      unique case (state_q)
        PutIdle: begin
          state_d = PutIdle;
        end
        PutLookup: begin
          lat_cnt_d = LatCntW'(LOOKUP_LAT - 1);
          to_cnt_d  = '0;
          state_d   = PutWait;
        end
        PutWait: begin
          if (lat_cnt_q == '0) begin
            // Hit wins over a free slot: overwrite in place.
            if (hit) begin
              wr_idx_d    = hit_idx;
              wr_update_d = 1'b1;
              state_d     = PutWrite;
            end else if (free_valid) begin
              wr_idx_d    = free_idx;
              wr_update_d = 1'b0;
              state_d     = PutWrite;
            end else begin
              err_code_d = ErrFull;
              state_d    = PutError;
            end
          end else begin
            lat_cnt_d = lat_cnt_q - 1'b1;
          end
        end
        PutWrite: begin
          to_cnt_d = to_cnt_inc;
          // An ack in the final allowed cycle still counts as success.
          if (wr_ack) begin
            state_d = PutDone;
          end else if (to_cnt_inc == ToCntW'(ACK_TIMEOUT)) begin
            err_code_d = ErrTimeout;
            state_d    = PutError;
          end
        end
        PutDone, PutError: begin
          to_cnt_d = '0;
          state_d  = PutIdle;
        end
        default: begin
          state_d = PutIdle;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= PutIdle;
      lat_cnt_q   <= '0;
      to_cnt_q    <= '0;
      wr_idx_q    <= '0;
      wr_update_q <= 1'b0;
      err_code_q  <= ErrNone;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      to_cnt_q    <= to_cnt_d;
      wr_idx_q    <= wr_idx_d;
      wr_update_q <= wr_update_d;
      err_code_q  <= err_code_d;
    end
  end

  // Moore output decode.
  always_comb begin
    lookup_req   = (state_q == PutLookup);
    wr_req       = (state_q == PutWrite);
    wr_idx       = wr_idx_q;
    wr_update    = wr_update_q;
    cmd          = '0;
    cmd.done     = (state_q == PutDone);
    cmd.error    = (state_q == PutError);
    // err_code_q keeps the last error internally; it is only presented with error.
    cmd.err_code = (state_q == PutError) ? err_code_q : ErrNone;
  end

endmodule : put_fsm

// File: tb/tb_put_fsm.sv
// Directed, table-driven bench for put_fsm (NUM_ENTRIES=16, LOOKUP_LAT=1,
// ACK_TIMEOUT=15), plus hand-written timeout sequences.
module tb_put_fsm;
  import ctrl_types_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, en, enter, hit, free_valid, wr_ack;
  logic [3:0] hit_idx, free_idx;
  logic       lookup_req, wr_req, wr_update;
  logic [3:0] wr_idx;
  sub_cmd_t   cmd;

  int n_checks = 0;
  int n_fail   = 0;

  put_fsm #(
    .NUM_ENTRIES(16),
    .LOOKUP_LAT (1),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .enter     (enter),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .free_valid(free_valid),
    .free_idx  (free_idx),
    .wr_ack    (wr_ack),
    .lookup_req(lookup_req),
    .wr_req    (wr_req),
    .wr_idx    (wr_idx),
    .wr_update (wr_update),
    .cmd       (cmd)
  );

  always #5 clk = ~clk;

  // Inputs and expected outputs {lookup_req, wr_req, wr_idx, wr_update, done, error, err_code}.
  typedef struct {
    logic        rst_n, en, enter, hit;
    logic [3:0]  hit_idx;
    logic        free_valid;
    logic [3:0]  free_idx;
    logic        wr_ack;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, input logic e, input logic ent, input logic h,
                             input logic [3:0] hi, input logic fv, input logic [3:0] fi,
                             input logic ack, input logic lr, input logic wq,
                             input logic [3:0] wi, input logic wu, input logic d,
                             input logic er, input logic [1:0] ec);
    vec_t t;
    t.rst_n = r; t.en = e; t.enter = ent; t.hit = h; t.hit_idx = hi;
    t.free_valid = fv; t.free_idx = fi; t.wr_ack = ack;
    t.exp = {lr, wq, wi, wu, d, er, ec};
    return t;
  endfunction

  function automatic logic [10:0] outs();
    return {lookup_req, wr_req, wr_idx, wr_update, cmd.done, cmd.error, 2'(cmd.err_code)};
  endfunction

  task automatic apply(input logic r, input logic e, input logic ent, input logic h,
                       input logic [3:0] hi, input logic fv, input logic [3:0] fi,
                       input logic ack);
    rst_n = r; en = e; enter = ent; hit = h; hit_idx = hi;
    free_valid = fv; free_idx = fi; wr_ack = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  int cnt;

  initial begin
    apply(0, 0, 0, 0, 0, 0, 0, 0);

    //          rst en ent hit hidx fv fidx ack | lr wq widx wu d er ec
    vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0)); // 0 reset
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0)); // 1 idle
    // Miss with free slot 5.
    vecs.push_back(v(1, 1, 1, 0, 0, 1, 5, 0,   1, 0, 0, 0, 0, 0, 0)); // 2 LOOKUP
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 5, 0,   0, 0, 0, 0, 0, 0, 0)); // 3 WAIT
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 5, 1,   0, 1, 5, 0, 0, 0, 0)); // 4 WRITE
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 5, 1,   0, 0, 5, 0, 1, 0, 0)); // 5 DONE
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 5, 0,   0, 0, 5, 0, 0, 0, 0)); // 6 IDLE
    // Hit overwrite at 3 (free slot 7 ignored).
    vecs.push_back(v(1, 1, 1, 1, 3, 1, 7, 0,   1, 0, 5, 0, 0, 0, 0)); // 7
    vecs.push_back(v(1, 1, 0, 1, 3, 1, 7, 0,   0, 0, 5, 0, 0, 0, 0)); // 8
    vecs.push_back(v(1, 1, 0, 1, 3, 1, 7, 1,   0, 1, 3, 1, 0, 0, 0)); // 9
    vecs.push_back(v(1, 1, 0, 1, 3, 1, 7, 1,   0, 0, 3, 1, 1, 0, 0)); // 10
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 3, 1, 0, 0, 0)); // 11
    // Full: no wr_req, error FULL for one cycle.
    vecs.push_back(v(1, 1, 1, 0, 0, 0, 0, 0,   1, 0, 3, 1, 0, 0, 0)); // 12
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 3, 1, 0, 0, 0)); // 13
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 3, 1, 0, 1, 1)); // 14
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 3, 1, 0, 0, 0)); // 15
    // en stalls: 3 in WAIT, 3 in WRITE with ack ignored while en=0.
    vecs.push_back(v(1, 1, 1, 0, 0, 1, 9, 0,   1, 0, 3, 1, 0, 0, 0)); // 16
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 9, 0,   0, 0, 3, 1, 0, 0, 0)); // 17
    vecs.push_back(v(1, 0, 0, 0, 0, 1, 9, 0,   0, 0, 3, 1, 0, 0, 0)); // 18
    vecs.push_back(v(1, 0, 0, 0, 0, 1, 9, 0,   0, 0, 3, 1, 0, 0, 0)); // 19
    vecs.push_back(v(1, 0, 0, 0, 0, 1, 9, 0,   0, 0, 3, 1, 0, 0, 0)); // 20
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 9, 0,   0, 1, 9, 0, 0, 0, 0)); // 21
    vecs.push_back(v(1, 0, 0, 0, 0, 1, 2, 1,   0, 1, 9, 0, 0, 0, 0)); // 22
    vecs.push_back(v(1, 0, 0, 0, 0, 1, 2, 1,   0, 1, 9, 0, 0, 0, 0)); // 23
    vecs.push_back(v(1, 0, 0, 0, 0, 1, 2, 1,   0, 1, 9, 0, 0, 0, 0)); // 24
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 2, 1,   0, 0, 9, 0, 1, 0, 0)); // 25
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 2, 0,   0, 0, 9, 0, 0, 0, 0)); // 26
    // Abort by enter mid-WRITE, then reset mid-WRITE.
    vecs.push_back(v(1, 1, 1, 0, 0, 1, 2, 0,   1, 0, 9, 0, 0, 0, 0)); // 27
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 2, 0,   0, 0, 9, 0, 0, 0, 0)); // 28
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 2, 0,   0, 1, 2, 0, 0, 0, 0)); // 29
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 2, 0,   0, 1, 2, 0, 0, 0, 0)); // 30
    vecs.push_back(v(1, 1, 1, 0, 0, 1, 2, 1,   1, 0, 2, 0, 0, 0, 0)); // 31
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 2, 0,   0, 0, 2, 0, 0, 0, 0)); // 32
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 2, 0,   0, 1, 2, 0, 0, 0, 0)); // 33
    vecs.push_back(v(0, 1, 0, 0, 0, 1, 2, 1,   0, 0, 0, 0, 0, 0, 0)); // 34
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0)); // 35
    // enter overrides en=0; en=0 holds LOOKUP; reset beats enter.
    vecs.push_back(v(1, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0)); // 36
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0)); // 37
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0)); // 38
    vecs.push_back(v(0, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0)); // 39
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0)); // 40

    foreach (vecs[i]) begin
      apply(vecs[i].rst_n, vecs[i].en, vecs[i].enter, vecs[i].hit, vecs[i].hit_idx,
            vecs[i].free_valid, vecs[i].free_idx, vecs[i].wr_ack);
      tick();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Timeout: no ack, wr_req must stay high for exactly 15 cycles, then TIMEOUT.
    apply(1, 1, 1, 0, 0, 1, 4, 0);
    tick();
    enter = 1'b0;
    tick();
    tick();
    check("to_write_entry", 32'({wr_req, wr_idx}), 32'({1'b1, 4'd4}));
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (cmd.error || cmd.done) break;
      if (wr_req) cnt++;
      tick();
    end
    check("to_req_cycles", 32'(cnt), 32'd15);
    check("to_error", 32'({cmd.done, cmd.error, 2'(cmd.err_code)}), 32'({1'b0, 1'b1, 2'd2}));
    tick();
    check("to_idle", 32'({lookup_req, wr_req, cmd.done, cmd.error}), 32'd0);

    // Ack in the 15th WRITE cycle is still a success.
    apply(1, 1, 1, 0, 0, 1, 6, 0);
    tick();
    enter = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 14; i++) tick();
    check("late_ack_req", 32'({wr_req, cmd.error}), 32'({1'b1, 1'b0}));
    wr_ack = 1'b1;
    tick();
    check("late_ack_done", 32'({wr_req, cmd.done, cmd.error}), 32'({1'b0, 1'b1, 1'b0}));
    wr_ack = 1'b0;
    tick();
    check("late_ack_idle", 32'({wr_req, cmd.done, cmd.error}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_put_fsm
